fp_sum_requester: RTL and testbench
===================================

Name: fp_sum_requester

Overview:
- Initiator-side client of the team's single-precision float adder (stb/ack responder).
- Accepts a start command with an element count, pulls that many IEEE-754 floats from an upstream valid/ready stream, and issues acc + x transactions to the adder one at a time.
- Returns the final sum on a valid/ready output.
- Sits between DMA/stream logic and the adder in the floatopt user subsystem.

Parameters:
CNT_W, 16, width of the element count and internal counter

Ports:
clk  input  1  clock
rstnn  input  1  reset; one clock, synchronous, active-low (decided)
start  input  1  command pulse; sampled only in IDLE
count  input  CNT_W  number of elements to sum; sampled with start
busy  output  1  high in every state except IDLE
in_data  input  32  float element
in_valid  input  1  element valid
in_ready  output  1  element accepted when in_valid & in_ready
add_a  output  32  operand A to adder (accumulator)
add_b  output  32  operand B to adder (element)
add_a_stb  output  1  operand strobe A
add_b_stb  output  1  operand strobe B, always equal to add_a_stb
add_a_ack  input  1  adder operand acknowledge
add_b_ack  input  1  unused; the adder never drives it
add_z  input  32  adder result
add_z_stb  input  1  result strobe
add_z_ack  output  1  result acknowledge
sum  output  32  final float sum
sum_valid  output  1  sum valid
sum_ready  input  1  downstream accepts sum

Behaviour:
- Reset (rstnn low at a clk edge): state IDLE; busy, in_ready, add_a_stb, add_b_stb, add_z_ack and sum_valid are 0; add_a, add_b and sum are 32'h0; accumulator is 32'h0; counter is 0.
- Reset mid-operation aborts immediately, with no drain.
- The adder itself must be reset alongside this block.
- States: IDLE, FETCH, ISSUE, WAIT_Z, DONE.
- IDLE:
  - in_ready = 0.
  - On start: load rem = count and acc = 32'h0.
  - If count == 0, go to DONE with sum = 32'h00000000.
  - Otherwise go to FETCH.
  - start while not IDLE is ignored.
- FETCH:
  - in_ready = 1 (registered, asserted on FETCH entry).
  - On in_valid & in_ready: register add_b = in_data and add_a = acc.
  - Drop in_ready, assert both stbs, go to ISSUE.
  - The cycle after acceptance, in_ready is 0; exactly one element is accepted per FETCH.
- ISSUE:
  - add_a_stb and add_b_stb held high until a clk edge samples add_a_stb & add_a_ack high; both deassert the next cycle.
  - Then go to WAIT_Z.
  - add_a and add_b stay stable from stb assertion until the result is captured, because the adder samples operands one cycle after the handshake.
- WAIT_Z:
  - add_z_ack = 1.
  - On a clk edge with add_z_stb & add_z_ack: acc <= add_z, rem <= rem - 1, add_z_ack drops.
  - If rem == 1, go to DONE with sum <= add_z; else go to FETCH.
  - There is no timeout.
- DONE:
  - sum_valid = 1 and sum held stable.
  - On sum_valid & sum_ready: sum_valid drops next cycle and state returns to IDLE.
  - A start in the same cycle as the sum handshake is ignored.
- Throughput: exactly one adder transaction outstanding; elements are never buffered.
- Latency per element: 1 (accept) + adder handshake + adder compute + 1 (capture) cycles.
- No float arithmetic in this block.
  - Sums are bit-exact adder outputs.
  - The initial acc of +0 makes the first result equal to the element; the adder's zero rule gives -0 + +0 = +0 sign handling.
- count wraps nowhere: rem only decrements from a nonzero value and the block stops at 1 → 0.
- Simultaneous in_valid in IDLE or DONE is not accepted (in_ready = 0).

Test Plan:
- count=3, stream 3F800000, 40000000, 40400000 (1,2,3) → exactly 3 in handshakes, 3 adder transactions with add_a = 00000000, 3F800000, 40400000; sum = 40C00000, sum_valid one pulse when sum_ready is tied 1.
- count=0 with start → sum = 00000000, sum_valid next cycle, no in_ready and no add_a_stb ever asserted.
- count=2, in_valid gapped (low for 5 cycles between elements), stream 40000000, C0000000 → sum = 00000000 (positive zero); add_a and add_b stable throughout every ISSUE/WAIT_Z interval.
- sum_ready held low for 10 cycles after completion → sum_valid and sum stable; busy = 1; a start pulse during the hold is ignored; sum_ready high → IDLE next cycle.
- rstnn low for one cycle while in WAIT_Z (adder also reset) → all outputs at reset values the following cycle; a new start with count=1 and element 7F800000 → sum = 7F800000.
- Back-to-back commands, count=1 each, elements 3F800000 then BF800000 → sums 3F800000 then BF800000, with no state leakage between commands.

Source files
------------

// File: rtl/fp_sum_requester.sv
`default_nettype none
// ============================================================================
//  Module   : fp_sum_requester
//  Purpose  : Initiator-side client of the single-precision float adder.
//             On a start command it pulls `count` IEEE-754 floats from an
//             upstream valid/ready stream, runs acc + x through the adder
//             one transaction at a time (stb/ack protocol), and presents
//             the final accumulated sum on a valid/ready output.
//  Ports    : clk, rstnn          - clock, synchronous active-low reset
//             start, count, busy  - command interface
//             in_data/valid/ready - element stream (consumer side)
//             add_a/add_b/_stb/_ack, add_z/_stb/_ack - adder initiator side
//             sum, sum_valid, sum_ready - result (producer side)
//  Revision : 1.0 - initial release
// ============================================================================
module fp_sum_requester #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic             add_a_stb,
    output logic             add_b_stb,
    input  logic             add_a_ack,
    input  logic             add_b_ack,
    input  logic [31:0]      add_z,
    input  logic             add_z_stb,
    output logic             add_z_ack,
    output logic [31:0]      sum,
    output logic             sum_valid,
    input  logic             sum_ready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT_Z = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] rem;
    logic             op_stb;

    // The adder only ever looks at the A-side acknowledge; B is strobed in
    // lockstep with A and its acknowledge is never driven.
    logic unused_add_b_ack;
    assign unused_add_b_ack = add_b_ack;

    assign add_a_stb = op_stb;
    assign add_b_stb = op_stb;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state     <= S_IDLE;
            acc       <= 32'h0;
            rem       <= CNT_ZERO;
            op_stb    <= 1'b0;
            in_ready  <= 1'b0;
            add_a     <= 32'h0;
            add_b     <= 32'h0;
            add_z_ack <= 1'b0;
            sum       <= 32'h0;
            sum_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rem <= count;
                        acc <= 32'h0;
                        if (count == CNT_ZERO) begin
                            // Empty command: the sum of nothing is +0.
                            sum       <= 32'h0;
                            sum_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    if (in_valid && in_ready) begin
                        // Operands are frozen here and held until the result
                        // comes back, since the adder samples them a cycle
                        // after the operand handshake.
                        add_a    <= acc;
                        add_b    <= in_data;
                        in_ready <= 1'b0;
                        op_stb   <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (op_stb && add_a_ack) begin
                        op_stb    <= 1'b0;
                        add_z_ack <= 1'b1;
                        state     <= S_WAIT_Z;
                    end
                end

                S_WAIT_Z: begin
                    if (add_z_stb && add_z_ack) begin
                        acc       <= add_z;
                        rem       <= rem - CNT_ONE;
                        add_z_ack <= 1'b0;
                        if (rem == CNT_ONE) begin
                            sum       <= add_z;
                            sum_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    if (sum_valid && sum_ready) begin
                        sum_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_sum_requester.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_sum_requester
//  Purpose  : Self-checking bench for fp_sum_requester. Contains a stub float
//             adder responder, a fold-based reference model of the expected
//             adder transactions and sums, a per-cycle monitor and directed
//             scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_sum_requester;

    logic        clk = 1'b0;
    logic        rstnn;
    logic        start;
    logic [15:0] count;
    logic        busy;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] add_a, add_b;
    logic        add_a_stb, add_b_stb;
    logic        add_a_ack, add_b_ack;
    logic [31:0] add_z;
    logic        add_z_stb;
    logic        add_z_ack;
    logic [31:0] sum;
    logic        sum_valid;
    logic        sum_ready;

    always #5 clk = ~clk;

    fp_sum_requester #(.CNT_W(16)) dut (
        .clk(clk), .rstnn(rstnn), .start(start), .count(count), .busy(busy),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
        .add_a_ack(add_a_ack), .add_b_ack(add_b_ack), .add_z(add_z),
        .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
        .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (bound expired or unexpected event) at %0t", name, $time);
    endtask

    // Float addition for the exact operand pairs the scenarios use.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h00000000, 32'h3F800000}: return 32'h3F800000; // 0+1
            {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1+2
            {32'h40400000, 32'h40400000}: return 32'h40C00000; // 3+3
            {32'h00000000, 32'h40000000}: return 32'h40000000; // 0+2
            {32'h40000000, 32'hC0000000}: return 32'h00000000; // 2-2 = +0
            {32'h00000000, 32'h40400000}: return 32'h40400000; // 0+3
            {32'h00000000, 32'h7F800000}: return 32'h7F800000; // 0+inf
            {32'h00000000, 32'hBF800000}: return 32'hBF800000; // 0-1
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // ---------------- reference model (fold over the element list) --------
    logic [31:0] elems[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    logic [31:0] exp_sum[$];

    task automatic plan();
        logic [31:0] acc;
        acc = 32'h0;
        foreach (elems[i]) begin
            exp_a.push_back(acc);
            exp_b.push_back(elems[i]);
            acc = fadd(acc, elems[i]);
        end
        exp_sum.push_back(acc);
    endtask

    // ---------------- stub adder responder --------------------------------
    logic adder_rst = 1'b0;
    int   ack_dly = 0;
    int   z_dly   = 1;
    int   ad_st   = 0;
    int   dly     = 0;
    int   txn_cnt = 0;
    logic [31:0] ra, rb, rz;

    assign add_b_ack = 1'b0;

    always @(negedge clk) begin
        if (!rstnn || adder_rst) begin
            add_a_ack = 1'b0;
            add_z_stb = 1'b0;
            add_z     = 32'h0;
            ad_st     = 0;
            dly       = 0;
        end else begin
            case (ad_st)
                0: if (add_a_stb) begin
                    ra = add_a; rb = add_b; dly = 0; ad_st = 4;
                end
                4: begin
                    chk("op_a_stable", add_a, ra);
                    chk("op_b_stable", add_b, rb);
                    if (dly >= ack_dly) begin add_a_ack = 1'b1; ad_st = 1; end
                    else dly++;
                end
                1: begin
                    // operand handshake happened on the last rising edge
                    add_a_ack = 1'b0;
                    chk("stb_drop", add_a_stb, 1'b0);
                    chk("op_a_stable", add_a, ra);
                    chk("op_b_stable", add_b, rb);
                    if (exp_a.size() == 0) fail_now("unexpected_txn");
                    else begin
                        chk("txn_a", add_a, exp_a.pop_front());
                        chk("txn_b", add_b, exp_b.pop_front());
                    end
                    txn_cnt++;
                    rz = fadd(ra, rb);
                    dly = 0;
                    ad_st = 2;
                end
                2: begin
                    chk("op_a_stable", add_a, ra);
                    chk("op_b_stable", add_b, rb);
                    if (dly >= z_dly) begin add_z = rz; add_z_stb = 1'b1; ad_st = 3; end
                    else dly++;
                end
                3: begin
                    chk("op_a_stable", add_a, ra);
                    if (!add_z_ack) begin add_z_stb = 1'b0; add_z = 32'h0; ad_st = 0; end
                end
                default: ad_st = 0;
            endcase
        end
    end

    // ---------------- per-cycle monitor -----------------------------------
    int accepts = 0, rdy_cycles = 0, stb_rises = 0, sum_pulses = 0;
    logic        prev_sv = 1'b0, prev_stb = 1'b0;
    logic [31:0] prev_sum = 32'h0, last_sum = 32'h0;

    always @(negedge clk) begin
        if (rstnn) begin
            chk("b_stb_eq_a_stb", add_b_stb, add_a_stb);
            if (in_ready) begin rdy_cycles++; chk("rdy_implies_busy", busy, 1'b1); end
            if (in_ready && in_valid) accepts++;
            if (add_a_stb && !prev_stb) stb_rises++;
            if (sum_valid) chk("sv_implies_busy", busy, 1'b1);
            if (sum_valid && !prev_sv) begin
                if (exp_sum.size() == 0) fail_now("unexpected_sum");
                else chk("sum", sum, exp_sum.pop_front());
                last_sum = sum;
                sum_pulses++;
            end
            if (sum_valid && prev_sv) chk("sum_hold", sum, prev_sum);
        end
        prev_sv  = sum_valid;
        prev_stb = add_a_stb;
        prev_sum = sum;
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic do_start(input logic [15:0] n);
        start = 1'b1; count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input int gap);
        int t;
        in_data = d; in_valid = 1'b1;
        for (t = 0; t < 500; t++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (t >= 500) fail_now("push_timeout");
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 1000; t++) begin
            if (!busy) break;
            @(negedge clk);
        end
        if (t >= 1000) fail_now("idle_timeout");
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_a_stb", add_a_stb, 1'b0);
        chk("rst_b_stb", add_b_stb, 1'b0);
        chk("rst_z_ack", add_z_ack, 1'b0);
        chk("rst_sum_valid", sum_valid, 1'b0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_add_b", add_b, 32'h0);
        chk("rst_sum", sum, 32'h0);
    endtask

    // ---------------- directed scenarios ----------------------------------
    initial begin
        int a0, t0, p0, r0, s0, t;
        rstnn = 1'b0; start = 1'b0; count = '0; in_data = '0; in_valid = 1'b0;
        sum_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rstnn = 1'b1;
        @(negedge clk);

        // 1+2+3 with sum_ready tied high
        elems = '{32'h3F800000, 32'h40000000, 32'h40400000}; plan();
        a0 = accepts; t0 = txn_cnt; p0 = sum_pulses;
        do_start(16'd3);
        chk("busy_after_start", busy, 1'b1);
        foreach (elems[i]) push(elems[i], 0);
        wait_idle();
        chk("t1_accepts", accepts - a0, 3);
        chk("t1_txns", txn_cnt - t0, 3);
        chk("t1_pulses", sum_pulses - p0, 1);
        chk("t1_sum_literal", last_sum, 32'h40C00000);
        chk("t1_sv_low", sum_valid, 1'b0);

        // count = 0
        elems = {}; plan();
        r0 = rdy_cycles; s0 = stb_rises; p0 = sum_pulses;
        do_start(16'd0);
        chk("t2_sv", sum_valid, 1'b1);
        chk("t2_sum", sum, 32'h0);
        chk("t2_in_ready", in_ready, 1'b0);
        wait_idle();
        chk("t2_rdy_cycles", rdy_cycles - r0, 0);
        chk("t2_stb_rises", stb_rises - s0, 0);
        chk("t2_pulses", sum_pulses - p0, 1);

        // 2 + -2 with gapped stream and slow adder
        ack_dly = 2; z_dly = 3;
        elems = '{32'h40000000, 32'hC0000000}; plan();
        a0 = accepts;
        do_start(16'd2);
        push(elems[0], 5);
        push(elems[1], 0);
        wait_idle();
        chk("t3_accepts", accepts - a0, 2);
        chk("t3_sum_literal", last_sum, 32'h00000000);

        // sum held by back-pressure; start during hold ignored
        ack_dly = 0; z_dly = 1; sum_ready = 1'b0;
        elems = '{32'h40400000}; plan();
        do_start(16'd1);
        push(elems[0], 0);
        for (t = 0; t < 200; t++) begin
            if (sum_valid) break;
            @(negedge clk);
        end
        if (t >= 200) fail_now("t4_sv_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_busy", busy, 1'b1);
            chk("t4_sv", sum_valid, 1'b1);
            chk("t4_sum", sum, 32'h40400000);
            if (i == 3) begin start = 1'b1; count = 16'd5; end
            if (i == 4) start = 1'b0;
        end
        sum_ready = 1'b1;
        @(negedge clk);
        chk("t4_sv_drop", sum_valid, 1'b0);
        chk("t4_idle", busy, 1'b0);
        in_valid = 1'b1; in_data = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_no_restart", busy, 1'b0);
            chk("t4_idle_no_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;

        // reset while waiting on the adder result
        z_dly = 6;
        elems = '{32'h3F800000, 32'h40000000}; plan();
        do_start(16'd2);
        push(elems[0], 0);
        for (t = 0; t < 200; t++) begin
            if (add_z_ack) break;
            @(negedge clk);
        end
        if (t >= 200) fail_now("t5_waitz_timeout");
        rstnn = 1'b0; adder_rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rstnn = 1'b1;
        exp_a = {}; exp_b = {}; exp_sum = {};
        @(negedge clk);
        adder_rst = 1'b0;
        z_dly = 1;
        elems = '{32'h7F800000}; plan();
        do_start(16'd1);
        push(elems[0], 0);
        wait_idle();
        chk("t5_sum_literal", last_sum, 32'h7F800000);

        // back-to-back single-element commands
        elems = '{32'h3F800000}; plan();
        do_start(16'd1);
        push(elems[0], 0);
        wait_idle();
        chk("t6a_sum_literal", last_sum, 32'h3F800000);
        elems = '{32'hBF800000}; plan();
        do_start(16'd1);
        push(elems[0], 0);
        wait_idle();
        chk("t6b_sum_literal", last_sum, 32'hBF800000);

        chk("model_drained_a", exp_a.size(), 0);
        chk("model_drained_sum", exp_sum.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
